// File: rtl/aes_cipher_arbiter.sv
// Round-robin arbiter and sequencer that shares one AES_Cipher core between two requesters.
// Optional RUN-phase timeout abort is compiled in when AES_ARB_TIMEOUT_EN is defined.
module aes_cipher_arbiter #(
    parameter int TIMEOUT_CYCLES = 32,
    parameter int CNT_W          = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [127:0] req0_plain_text,
    input  logic [127:0] req0_key,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [127:0] req1_plain_text,
    input  logic [127:0] req1_key,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [127:0] rsp_cipher_text,
    output logic         rsp_error,
    output logic         core_rst_n,
    output logic [127:0] core_plain_text,
    output logic [127:0] core_cipher_key,
    input  logic [127:0] core_cipher_text,
    input  logic         core_cipher_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t       state_r;
    logic         last_r;
    logic         owner_r;
    logic         core_rst_r;
    logic [127:0] core_pt_r;
    logic [127:0] core_key_r;
    logic         rsp_valid_r;
    logic         rsp_id_r;
    logic [127:0] rsp_ct_r;
    logic         rsp_error_r;

    logic         grant_s;
    logic         is_idle_s;
    logic         take_s;
    logic         timeout_s;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (2 ** CNT_W) - 1) begin : g_cfg_check
        $error("aes_cipher_arbiter: TIMEOUT_CYCLES does not fit the CNT_W counter");
    end

    // Arbitration: a lone requester wins; under contention the one not granted last wins.
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_s = ~last_r;
        end else if (req0_valid) begin
            grant_s = 1'b0;
        end else begin
            grant_s = 1'b1;
        end
    end

    assign is_idle_s  = (state_r == IDLE);
    assign req0_ready = is_idle_s && !grant_s && req0_valid;
    assign req1_ready = is_idle_s &&  grant_s && req1_valid;
    assign take_s     = req0_ready || req1_ready;

`ifdef AES_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_r;

    // The abort fires on the RUN cycle whose increment would bring the count to TIMEOUT_CYCLES.
    assign timeout_s = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

    // RUN-cycle counter: cleared in LOAD, saturating increment while RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == LOAD) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == RUN && cnt_r != {CNT_W{1'b1}}) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Sequencer FSM with all core and response outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            last_r      <= 1'b1;
            owner_r     <= 1'b0;
            core_rst_r  <= 1'b0;
            core_pt_r   <= 128'd0;
            core_key_r  <= 128'd0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= 1'b0;
            rsp_ct_r    <= 128'd0;
            rsp_error_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (take_s) begin
                        core_pt_r  <= grant_s ? req1_plain_text : req0_plain_text;
                        core_key_r <= grant_s ? req1_key : req0_key;
                        owner_r    <= grant_s;
                        last_r     <= grant_s;
                        state_r    <= LOAD;
                    end
                end
                LOAD: begin
                    // Core held in reset for this one cycle with the operands already stable.
                    core_rst_r <= 1'b1;
                    state_r    <= RUN;
                end
                RUN: begin
                    if (core_cipher_ready) begin
                        rsp_ct_r    <= core_cipher_text;
                        rsp_error_r <= 1'b0;
                        rsp_id_r    <= owner_r;
                        rsp_valid_r <= 1'b1;
                        core_rst_r  <= 1'b0;
                        state_r     <= DONE;
                    end else if (timeout_s) begin
                        rsp_ct_r    <= 128'd0;
                        rsp_error_r <= 1'b1;
                        rsp_id_r    <= owner_r;
                        rsp_valid_r <= 1'b1;
                        core_rst_r  <= 1'b0;
                        state_r     <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    core_rst_r  <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign core_rst_n      = core_rst_r & rst_n;
    assign core_plain_text = core_pt_r;
    assign core_cipher_key = core_key_r;
    assign rsp_valid       = rsp_valid_r;
    assign rsp_id          = rsp_id_r;
    assign rsp_cipher_text = rsp_ct_r;
    assign rsp_error       = rsp_error_r;

endmodule

// File: tb/tb_aes_cipher_arbiter.sv
// Self-checking bench for aes_cipher_arbiter: stubbed cipher core, random traffic,
// transaction-level reference model checked every cycle, plus directed literal checks.
module tb_aes_cipher_arbiter;

    localparam int TO = 8;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [127:0] req0_plain_text = 128'd0, req0_key = 128'd0;
    logic [127:0] req1_plain_text = 128'd0, req1_key = 128'd0;
    logic         rsp_valid, rsp_id, rsp_error;
    logic         rsp_ready = 1'b1;
    logic [127:0] rsp_cipher_text;
    logic         core_rst_n;
    logic [127:0] core_plain_text, core_cipher_key, core_cipher_text;
    logic         core_cipher_ready;

    aes_cipher_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_plain_text(req0_plain_text), .req0_key(req0_key),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_plain_text(req1_plain_text), .req1_key(req1_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_cipher_text(rsp_cipher_text), .rsp_error(rsp_error),
        .core_rst_n(core_rst_n), .core_plain_text(core_plain_text),
        .core_cipher_key(core_cipher_key), .core_cipher_text(core_cipher_text),
        .core_cipher_ready(core_cipher_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Cipher stand-in: the known FIPS-197 vector, otherwise a fixed keyed scramble.
    function automatic logic [127:0] core_ref(input logic [127:0] pt, input logic [127:0] key);
        if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
        return {pt[63:0], pt[127:64]} ^ {key[126:0], key[127]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    // Stub core: ready core_lat cycles after its reset releases; random stray ready while in reset.
    int           stub_cnt = 0;
    int           core_lat = 2;
    logic         stray_r = 1'b0;
    logic [127:0] noise_r = 128'd0;
    always @(posedge clk) begin
        stub_cnt <= core_rst_n ? stub_cnt + 1 : 0;
        stray_r  <= ($urandom_range(0, 3) == 0);
        noise_r  <= rnd128();
    end
    assign core_cipher_ready = core_rst_n ? (stub_cnt >= core_lat) : stray_r;
    assign core_cipher_text  = (core_rst_n && stub_cnt >= core_lat) ?
                               core_ref(core_plain_text, core_cipher_key) : noise_r;

    // Reference model state (transaction level, timestamps in cycles).
    bit           m_busy = 0, m_done = 0, m_first = 0, m_last = 1, m_id = 0, m_err = 0;
    logic [127:0] m_pt = 128'd0, m_key = 128'd0, m_ct = 128'd0;
    int           m_t = 0, t_ready = 0, t_rise = 0, t_hs_last = 0, acc_cyc = 0, n_rsp = 0;
    bit           hs0 = 0, hs1 = 0;
    bit           last_id = 0, last_err = 0;
    logic [127:0] last_ct = 128'd0;
    bit           gq[$];

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        bit e0, e1, g;
        if (!rst_n) begin
            check("rst_core_rst_n", 128'(core_rst_n), 128'd0);
            check("rst_rsp_valid", 128'(rsp_valid), 128'd0);
            check("rst_rsp_id", 128'(rsp_id), 128'd0);
            check("rst_rsp_error", 128'(rsp_error), 128'd0);
            check("rst_rsp_ct", rsp_cipher_text, 128'd0);
            check("rst_core_pt", core_plain_text, 128'd0);
            check("rst_core_key", core_cipher_key, 128'd0);
            m_busy = 0; m_done = 0; m_last = 1; m_pt = 128'd0; m_key = 128'd0;
            hs0 = 0; hs1 = 0;
        end else begin
            g  = (req0_valid && req1_valid) ? !m_last : !req0_valid;
            e0 = !m_busy && req0_valid && !g;
            e1 = !m_busy && req1_valid && g;
            check("req0_ready", 128'(req0_ready), 128'(e0));
            check("req1_ready", 128'(req1_ready), 128'(e1));
            check("core_plain_text", core_plain_text, m_pt);
            check("core_cipher_key", core_cipher_key, m_key);
            hs0 = e0; hs1 = e1;
            if (!m_busy) begin
                check("idle_core_rst_n", 128'(core_rst_n), 128'd0);
                check("idle_rsp_valid", 128'(rsp_valid), 128'd0);
                if (e0 || e1) begin
                    m_busy = 1; m_done = 0; m_first = 1;
                    m_t = cyc; t_hs_last = cyc;
                    m_id = e1; m_last = e1;
                    m_pt  = e1 ? req1_plain_text : req0_plain_text;
                    m_key = e1 ? req1_key : req0_key;
                    gq.push_back(e1);
                end
            end else if (!m_done) begin
                check("busy_rsp_valid", 128'(rsp_valid), 128'd0);
                if (cyc < m_t + 2) begin
                    check("load_core_rst_n", 128'(core_rst_n), 128'd0);
                end else begin
                    check("run_core_rst_n", 128'(core_rst_n), 128'd1);
                    if (core_cipher_ready) begin
                        m_done = 1; m_err = 0; m_ct = core_ref(m_pt, m_key); t_ready = cyc;
                    end
`ifdef AES_ARB_TIMEOUT_EN
                    else if (cyc - m_t - 2 == TO - 1) begin
                        m_done = 1; m_err = 1; m_ct = 128'd0;
                    end
`endif
                end
            end else begin
                check("done_rsp_valid", 128'(rsp_valid), 128'd1);
                check("done_core_rst_n", 128'(core_rst_n), 128'd0);
                check("rsp_id", 128'(rsp_id), 128'(m_id));
                check("rsp_cipher_text", rsp_cipher_text, m_ct);
                check("rsp_error", 128'(rsp_error), 128'(m_err));
                if (m_first) begin
                    t_rise = cyc; m_first = 0;
                end
                if (rsp_ready) begin
                    m_busy = 0; m_done = 0; n_rsp++; acc_cyc = cyc;
                    last_id = rsp_id; last_err = rsp_error; last_ct = rsp_cipher_text;
                end
            end
        end
    end

    // Stimulus knobs: genN 0=off 1=random 2=always; rr_mode 0=stall 1=random 2=always ready.
    int gen0 = 0, gen1 = 0, rr_mode = 2, lat_rand = 0, lat_lo = 0, lat_hi = 5;

    task automatic tick();
        @(posedge clk);
        #1;
        if (hs0) req0_valid = 1'b0;
        if (hs1) req1_valid = 1'b0;
        if (!req0_valid && gen0 != 0 && (gen0 == 2 || $urandom_range(0, 2) == 0)) begin
            req0_valid = 1'b1; req0_plain_text = rnd128(); req0_key = rnd128();
        end
        if (!req1_valid && gen1 != 0 && (gen1 == 2 || $urandom_range(0, 2) == 0)) begin
            req1_valid = 1'b1; req1_plain_text = rnd128(); req1_key = rnd128();
        end
        case (rr_mode)
            0:       rsp_ready = 1'b0;
            1:       rsp_ready = 1'($urandom_range(0, 1));
            default: rsp_ready = 1'b1;
        endcase
        if ((hs0 || hs1) && lat_rand != 0) core_lat = int'($urandom_range(lat_lo, lat_hi));
    endtask

    task automatic wait_rsp(input int target, input int budget);
        int n = 0;
        while (n_rsp < target && n < budget) begin
            tick();
            n++;
        end
        check("wait_rsp_count", 128'(n_rsp >= target), 128'd1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((req0_valid || req1_valid || m_busy) && n < budget) begin
            tick();
            n++;
        end
        check("wait_idle", 128'(req0_valid || req1_valid || m_busy), 128'd0);
    endtask

    task automatic single_req(input bit id, input logic [127:0] pt, input logic [127:0] key, input int lat);
        core_lat = lat;
        if (id) begin
            req1_valid = 1'b1; req1_plain_text = pt; req1_key = key;
        end else begin
            req0_valid = 1'b1; req0_plain_text = pt; req0_key = key;
        end
    endtask

    initial begin
        int n;
        #2 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // FIPS-197 vector through requester 0.
        single_req(1'b0, FIPS_PT, FIPS_KEY, 3);
        wait_rsp(n_rsp + 1, 100);
        check("fips_id", 128'(last_id), 128'd0);
        check("fips_ct", last_ct, FIPS_CT);
        check("fips_err", 128'(last_err), 128'd0);
        check("fips_latency", 128'(t_rise - t_ready), 128'd1);
        wait_idle(100);

        // Lone requester 1, then contention: expect alternation starting at requester 0.
        single_req(1'b1, rnd128(), rnd128(), 1);
        wait_rsp(n_rsp + 1, 100);
        check("req1_alone_id", 128'(last_id), 128'd1);
        gq.delete();
        gen0 = 2; gen1 = 2; core_lat = 2;
        tick();
        wait_rsp(n_rsp + 4, 200);
        gen0 = 0; gen1 = 0;
        check("contention_grants", 128'(gq.size() >= 4), 128'd1);
        check("contention_g0", 128'(gq[0]), 128'd0);
        check("contention_g1", 128'(gq[1]), 128'd1);
        check("contention_g2", 128'(gq[2]), 128'd0);
        check("contention_g3", 128'(gq[3]), 128'd1);
        wait_idle(200);

        // Back-pressure with the other requester waiting.
        rr_mode = 0;
        single_req(1'b0, rnd128(), rnd128(), 2);
        req1_valid = 1'b1; req1_plain_text = rnd128(); req1_key = rnd128();
        n = 0;
        while (!rsp_valid && n < 50) begin
            tick();
            n++;
        end
        repeat (10) tick();
        check("bp_rsp_valid", 128'(rsp_valid), 128'd1);
        check("bp_req0_ready", 128'(req0_ready), 128'd0);
        check("bp_req1_ready", 128'(req1_ready), 128'd0);
        rr_mode = 2;
        n = n_rsp;
        wait_rsp(n + 1, 20);
        tick();
        tick();
        check("bp_next_grant", 128'(t_hs_last - acc_cyc), 128'd1);
        wait_idle(100);

`ifdef AES_ARB_TIMEOUT_EN
        // Timeout, ready coinciding with the last RUN cycle, and one cycle too late.
        single_req(1'b0, rnd128(), rnd128(), 255);
        wait_rsp(n_rsp + 1, 100);
        check("to_err", 128'(last_err), 128'd1);
        check("to_ct", last_ct, 128'd0);
        check("to_rise", 128'(t_rise - t_hs_last), 128'd10);
        single_req(1'b1, rnd128(), rnd128(), TO - 1);
        wait_rsp(n_rsp + 1, 100);
        check("to_tie_err", 128'(last_err), 128'd0);
        single_req(1'b0, rnd128(), rnd128(), TO);
        wait_rsp(n_rsp + 1, 100);
        check("to_late_err", 128'(last_err), 128'd1);
        wait_idle(100);
`endif

        // Reset mid-RUN after a requester-0 grant; next contention must start at requester 0.
        single_req(1'b0, rnd128(), rnd128(), 20);
        n = 0;
        while (!core_rst_n && n < 20) begin
            tick();
            n++;
        end
        tick();
        rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        check("midrst_core_rst_n", 128'(core_rst_n), 128'd0);
        check("midrst_rsp_valid", 128'(rsp_valid), 128'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        gq.delete();
        req0_valid = 1'b1; req0_plain_text = rnd128(); req0_key = rnd128();
        req1_valid = 1'b1; req1_plain_text = rnd128(); req1_key = rnd128();
        core_lat = 2;
        wait_rsp(n_rsp + 2, 100);
        check("postrst_g0", 128'(gq[0]), 128'd0);
        check("postrst_g1", 128'(gq[1]), 128'd1);
        wait_idle(100);

        // Random traffic.
        gen0 = 1; gen1 = 1; rr_mode = 1; lat_rand = 1; lat_lo = 0;
`ifdef AES_ARB_TIMEOUT_EN
        lat_hi = 10;
`else
        lat_hi = 5;
`endif
        repeat (3000) tick();
        gen0 = 0; gen1 = 0; rr_mode = 2;
        wait_idle(500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
